// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared 8:1 single-bit mux.
// Grants one requester at a time; a bounded tenure stops a holder from starving waiting requesters.
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       req,
  output logic [7:0]       grant,
  output logic [2:0]       sel,
  output logic             busy,
  output logic [CNT_W-1:0] hold_cnt,
  output logic             state_o
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  // Saturation point of the tenure counter; all-ones when tenure is unlimited.
  localparam logic [CNT_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? '1 : CNT_W'(MAX_HOLD);
  localparam logic             PREEMPT_EN = (MAX_HOLD != 0);

  state_t           state_q, state_d;
  logic [7:0]       grant_q, grant_d;
  logic [2:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [2:0]       last_q, last_d;

  logic [7:0] others;
  logic [2:0] win_all, win_others;
  logic       new_grant;
  logic [2:0] new_idx;

  // First set bit of v scanning upward from ptr+1, wrapping 7 -> 0; ptr itself ranks last.
  function automatic logic [2:0] rr_pick(input logic [7:0] v, input logic [2:0] ptr);
    logic [2:0] idx;
    logic       found;
    found   = 1'b0;
    rr_pick = '0;
    for (int i = 1; i <= 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && v[idx]) begin
        found   = 1'b1;
        rr_pick = idx;
      end
    end
  endfunction

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    hold_d     = hold_q;
    last_d     = last_q;
    new_grant  = 1'b0;
    new_idx    = '0;
    others     = req & ~(8'b1 << sel_q);
    win_all    = rr_pick(req, last_q);
    win_others = rr_pick(others, last_q);

    case (state_q)
      IDLE: begin
        if (|req) begin
          new_grant = 1'b1;
          new_idx   = win_all;
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          if (|others) begin
            new_grant = 1'b1;
            new_idx   = win_all;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            hold_d  = '0;
          end
        end else if (PREEMPT_EN && (hold_q >= HOLD_SAT) && (|others)) begin
          new_grant = 1'b1;
          new_idx   = win_others;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (new_grant) begin
      state_d = GRANT;
      last_d  = new_idx;
      sel_d   = new_idx;
      grant_d = 8'b1 << new_idx;
      busy_d  = 1'b1;
      hold_d  = CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
      last_q  <= 3'd7;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  assign grant    = grant_q;
  assign sel      = sel_q;
  assign busy     = busy_q;
  assign hold_cnt = hold_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: one instance with tenure 4, one with unlimited tenure.
// Expected outputs are pushed per step and popped after the clock edge that produces them.
module tb_mux_rr_arbiter;

  localparam int W = 21;  // {state, busy, grant[7:0], sel[2:0], hold[7:0]}

  logic       clk;
  logic       rst;
  logic [7:0] req;

  logic [7:0] grant_a, grant_b;
  logic [2:0] sel_a, sel_b;
  logic       busy_a, busy_b;
  logic [7:0] hold_a, hold_b;
  logic       state_a, state_b;

  logic [W-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  mux_rr_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req),
    .grant(grant_a), .sel(sel_a), .busy(busy_a), .hold_cnt(hold_a), .state_o(state_a)
  );

  mux_rr_arbiter #(.MAX_HOLD(0), .CNT_W(8)) dut_unl (
    .clk(clk), .rst(rst), .req(req),
    .grant(grant_b), .sel(sel_b), .busy(busy_b), .hold_cnt(hold_b), .state_o(state_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic [7:0] g, input logic [2:0] s,
                                      input logic b, input logic [7:0] h);
    mk = {b, b, g, s, h};
  endfunction

  // Drive one cycle of inputs, record what the chosen DUT must show after the edge, then check it.
  task automatic step(input logic rst_v, input logic [7:0] req_v, input logic use_unl,
                      input logic [W-1:0] e, input string tag);
    logic [W-1:0] obs;
    logic [W-1:0] want;
    @(negedge clk);
    rst = rst_v;
    req = req_v;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (use_unl) obs = {state_b, busy_b, grant_b, sel_b, hold_b};
    else         obs = {state_a, busy_a, grant_a, sel_a, hold_a};
    want = exp_q.pop_front();
    tests_run++;
    assert (obs === want) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  initial begin
    logic [2:0] s;
    rst = 1'b1;
    req = 8'h00;

    // 1: single requester, then release to idle with sel held
    step(1'b1, 8'h00, 1'b0, mk(8'h00, 3'd0, 1'b0, 8'd0), "t1_reset");
    step(1'b0, 8'h01, 1'b0, mk(8'h01, 3'd0, 1'b1, 8'd1), "t1_grant_c1");
    step(1'b0, 8'h01, 1'b0, mk(8'h01, 3'd0, 1'b1, 8'd2), "t1_grant_c2");
    step(1'b0, 8'h01, 1'b0, mk(8'h01, 3'd0, 1'b1, 8'd3), "t1_grant_c3");
    step(1'b0, 8'h00, 1'b0, mk(8'h00, 3'd0, 1'b0, 8'd0), "t1_idle");
    step(1'b0, 8'h00, 1'b0, mk(8'h00, 3'd0, 1'b0, 8'd0), "t1_idle2");

    // 2: all requesting, tenure 4 rotates 0..7 and back to 0
    step(1'b1, 8'h00, 1'b0, mk(8'h00, 3'd0, 1'b0, 8'd0), "t2_reset");
    for (int k = 0; k < 36; k++) begin
      s = 3'((k / 4) % 8);
      step(1'b0, 8'hFF, 1'b0, mk(8'h01 << s, s, 1'b1, 8'((k % 4) + 1)), "t2_rotate");
    end

    // 3: release handover with same-cycle arrivals, then last winner ranks lowest
    step(1'b1, 8'h00, 1'b0, mk(8'h00, 3'd0, 1'b0, 8'd0), "t3_reset");
    step(1'b0, 8'h08, 1'b0, mk(8'h08, 3'd3, 1'b1, 8'd1), "t3_hold3");
    step(1'b0, 8'h22, 1'b0, mk(8'h20, 3'd5, 1'b1, 8'd1), "t3_handover5");
    step(1'b0, 8'h22, 1'b0, mk(8'h20, 3'd5, 1'b1, 8'd2), "t3_keep5");
    step(1'b0, 8'h02, 1'b0, mk(8'h02, 3'd1, 1'b1, 8'd1), "t3_handover1");
    step(1'b0, 8'h00, 1'b0, mk(8'h00, 3'd1, 1'b0, 8'd0), "t3_idle_sel1");
    step(1'b0, 8'h03, 1'b0, mk(8'h01, 3'd0, 1'b1, 8'd1), "t3_last1_lowest");

    // 4: unlimited tenure never preempts; counter saturates at all-ones
    step(1'b1, 8'h00, 1'b1, mk(8'h00, 3'd0, 1'b0, 8'd0), "t4_reset");
    for (int k = 0; k < 300; k++) begin
      step(1'b0, 8'h44, 1'b1, mk(8'h04, 3'd2, 1'b1, (k < 255) ? 8'(k + 1) : 8'd255), "t4_hold2");
    end
    step(1'b0, 8'h40, 1'b1, mk(8'h40, 3'd6, 1'b1, 8'd1), "t4_pass6");

    // 5: lone requester is never preempted; counter saturates at 4
    step(1'b1, 8'h00, 1'b0, mk(8'h00, 3'd0, 1'b0, 8'd0), "t5_reset");
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 8'h10, 1'b0, mk(8'h10, 3'd4, 1'b1, (k < 4) ? 8'(k + 1) : 8'd4), "t5_lone4");
    end

    // 6: reset mid-grant overrides everything; first search after reset picks 6
    step(1'b1, 8'h00, 1'b0, mk(8'h00, 3'd0, 1'b0, 8'd0), "t6_reset");
    step(1'b0, 8'hC0, 1'b0, mk(8'h40, 3'd6, 1'b1, 8'd1), "t6_grant6");
    step(1'b0, 8'hC0, 1'b0, mk(8'h40, 3'd6, 1'b1, 8'd2), "t6_keep6");
    step(1'b1, 8'hC0, 1'b0, mk(8'h00, 3'd0, 1'b0, 8'd0), "t6_midreset");
    step(1'b0, 8'hC0, 1'b0, mk(8'h40, 3'd6, 1'b1, 8'd1), "t6_regrant6");
    step(1'b0, 8'hC0, 1'b0, mk(8'h40, 3'd6, 1'b1, 8'd2), "t6_keep6b");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
